// File: rtl/calc_entry_ctrl.sv
// Keypad operand-entry controller: builds two BCD operands and an op code from key codes and
// strobes calc_go on '='. Optional idle auto-clear is enabled with CALC_IDLE_CLR_EN.
//
// state | meaning
// S_A   | typing operand A
// S_B   | operator chosen, typing operand B
// S_RES | calc_go issued, operands held for the arithmetic stage
module calc_entry_ctrl #(
  parameter int DIGITS      = 3,
  parameter int IDLE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  output logic [3:0]            op_sign,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  output logic                  calc_go,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  entry_full,
  output logic [1:0]            state
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hC;
  localparam logic [3:0] K_BS  = 4'hD;
  localparam logic [3:0] K_CLR = 4'hE;

  localparam logic [3:0] SIGN_ADD = 4'd10;
  localparam logic [3:0] SIGN_SUB = 4'd0;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_RES = 2'b10
  } state_t;

  state_t          st_q, st_d;
  logic [W-1:0]    a_d, b_d;
  logic [3:0]      sign_d;
  logic [CW-1:0]   cnt_a, cnt_b, cnt_a_d, cnt_b_d;
  logic            go_d;
  logic            key_acc;
  logic            is_digit;
  logic            clr;
  logic            idle_tc;

  assign key_ready = ~calc_go;
  assign key_acc   = key_valid & key_ready;
  assign is_digit  = (key_code <= 4'd9);
  assign state     = st_q;

  assign disp_bcd   = (st_q == S_A) ? op_a : op_b;
  assign entry_full = (st_q == S_A) ? (cnt_a == CW'(DIGITS)) : (cnt_b == CW'(DIGITS));

`ifdef CALC_IDLE_CLR_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic [IW-1:0] idle_cnt;

  // Down-counter reloads on activity; terminal count means IDLE_CYCLES idle cycles have passed.
  assign idle_tc = (idle_cnt == '0) && !key_acc && (st_q != S_RES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= IW'(IDLE_CYCLES - 1);
    end else if (key_acc || (st_q == S_RES) || idle_tc) begin
      idle_cnt <= IW'(IDLE_CYCLES - 1);
    end else begin
      idle_cnt <= idle_cnt - IW'(1);
    end
  end
`else
  assign idle_tc = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    a_d     = op_a;
    b_d     = op_b;
    sign_d  = op_sign;
    cnt_a_d = cnt_a;
    cnt_b_d = cnt_b;
    go_d    = 1'b0;
    clr     = idle_tc;

    if (key_acc) begin
      if (key_code == K_CLR) begin
        clr = 1'b1;
      end else begin
        unique case (st_q)
          S_A: begin
            if (is_digit) begin
              if (cnt_a != CW'(DIGITS)) begin
                a_d     = W'({op_a, key_code});
                cnt_a_d = cnt_a + CW'(1);
              end
            end else if (key_code == K_BS) begin
              if (cnt_a != '0) begin
                a_d     = op_a >> 4;
                cnt_a_d = cnt_a - CW'(1);
              end
            end else if (key_code == K_ADD || key_code == K_SUB) begin
              sign_d  = (key_code == K_ADD) ? SIGN_ADD : SIGN_SUB;
              b_d     = '0;
              cnt_b_d = '0;
              st_d    = S_B;
            end
          end
          S_B: begin
            if (is_digit) begin
              if (cnt_b != CW'(DIGITS)) begin
                b_d     = W'({op_b, key_code});
                cnt_b_d = cnt_b + CW'(1);
              end
            end else if (key_code == K_BS) begin
              if (cnt_b != '0) begin
                b_d     = op_b >> 4;
                cnt_b_d = cnt_b - CW'(1);
              end
            end else if (key_code == K_ADD || key_code == K_SUB) begin
              sign_d = (key_code == K_ADD) ? SIGN_ADD : SIGN_SUB;
            end else if (key_code == K_EQ) begin
              go_d = 1'b1;
              st_d = S_RES;
            end
          end
          S_RES: begin
            // A fresh digit after a result starts a new calculation.
            if (is_digit) begin
              a_d     = W'(key_code);
              cnt_a_d = CW'(1);
              b_d     = '0;
              cnt_b_d = '0;
              st_d    = S_A;
            end else if (key_code == K_EQ) begin
              go_d = 1'b1;
            end
          end
          default: st_d = S_A;
        endcase
      end
    end

    if (clr) begin
      st_d    = S_A;
      a_d     = '0;
      b_d     = '0;
      sign_d  = SIGN_SUB;
      cnt_a_d = '0;
      cnt_b_d = '0;
      go_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_A;
      op_a    <= '0;
      op_b    <= '0;
      op_sign <= SIGN_SUB;
      cnt_a   <= '0;
      cnt_b   <= '0;
      calc_go <= 1'b0;
    end else begin
      st_q    <= st_d;
      op_a    <= a_d;
      op_b    <= b_d;
      op_sign <= sign_d;
      cnt_a   <= cnt_a_d;
      cnt_b   <= cnt_b_d;
      calc_go <= go_d;
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed key sequences plus random keys, all checked against a
// decimal-arithmetic model of the keypad entry rules.
module tb_calc_entry_ctrl;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int IDLE   = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'h0;
  logic         key_ready;
  logic [3:0]   op_sign;
  logic [W-1:0] op_a, op_b, disp_bcd;
  logic         calc_go, entry_full;
  logic [1:0]   state;

  calc_entry_ctrl #(.DIGITS(DIGITS), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .op_sign(op_sign), .op_a(op_a), .op_b(op_b),
    .calc_go(calc_go), .disp_bcd(disp_bcd), .entry_full(entry_full), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: operands as plain decimal integers with digit counts.
  int m_st, m_a, m_b, m_ac, m_bc, m_sign, m_go, m_idle;

  function automatic logic [W-1:0] bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_ac = 0; m_bc = 0; m_sign = 0; m_go = 0; m_idle = 0;
  endtask

  task automatic model_key(input int k);
    m_go = 0;
    m_idle = 0;
    if (k == 14) begin
      model_reset();
    end else if (m_st == 0) begin
      if (k <= 9) begin
        if (m_ac < DIGITS) begin m_a = m_a * 10 + k; m_ac++; end
      end else if (k == 13) begin
        if (m_ac > 0) begin m_a = m_a / 10; m_ac--; end
      end else if (k == 10 || k == 11) begin
        m_sign = (k == 10) ? 10 : 0;
        m_b = 0; m_bc = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (k <= 9) begin
        if (m_bc < DIGITS) begin m_b = m_b * 10 + k; m_bc++; end
      end else if (k == 13) begin
        if (m_bc > 0) begin m_b = m_b / 10; m_bc--; end
      end else if (k == 10 || k == 11) begin
        m_sign = (k == 10) ? 10 : 0;
      end else if (k == 12) begin
        m_go = 1; m_st = 2;
      end
    end else begin
      if (k <= 9) begin
        m_a = k; m_ac = 1; m_b = 0; m_bc = 0; m_st = 0;
      end else if (k == 12) begin
        m_go = 1;
      end
    end
  endtask

  // One clock edge without an accepted key.
  task automatic model_idle_tick();
    m_go = 0;
    if (m_st == 2) begin
      m_idle = 0;
    end else begin
      m_idle++;
`ifdef CALC_IDLE_CLR_EN
      if (m_idle == IDLE) model_reset();
`endif
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] ed;
    int ef;
    ed = (m_st == 0) ? bcd(m_a) : bcd(m_b);
    ef = (m_st == 0) ? int'(m_ac == DIGITS) : int'(m_bc == DIGITS);
    chk({tag, "/state"}, W'(state), W'(m_st));
    chk({tag, "/op_a"}, op_a, bcd(m_a));
    chk({tag, "/op_b"}, op_b, bcd(m_b));
    chk({tag, "/op_sign"}, W'(op_sign), W'(m_sign));
    chk({tag, "/calc_go"}, W'(calc_go), W'(m_go));
    chk({tag, "/key_ready"}, W'(key_ready), W'(m_go == 0));
    chk({tag, "/disp_bcd"}, disp_bcd, ed);
    chk({tag, "/entry_full"}, W'(entry_full), W'(ef));
  endtask

  // key_valid stays high afterwards so consecutive calls present keys back to back.
  task automatic send_key(input int k, output int stalls);
    string tag;
    tag = $sformatf("key_%h", k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    stalls = 0;
    while (!key_ready && stalls < 4) begin
      @(posedge clk);
      #1;
      model_idle_tick();
      check_all({tag, "_stall"});
      stalls++;
      @(negedge clk);
    end
    chk({tag, "/ready_timeout"}, W'(key_ready), W'(1));
    @(posedge clk);
    #1;
    model_key(k);
    check_all(tag);
  endtask

  task automatic send_seq(input int keys[$]);
    int s;
    foreach (keys[i]) send_key(keys[i], s);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      model_idle_tick();
      check_all("idle");
    end
  endtask

  initial begin
    int s;
    int exp_stall[6];
    int b2b[6];

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");

    // 123 - 45 =
    send_seq('{1, 2, 3, 11, 4, 5, 12});
    chk("t1/op_a", op_a, W'(12'h123));
    chk("t1/op_b", op_b, W'(12'h045));
    chk("t1/sign", W'(op_sign), W'(0));
    chk("t1/go", W'(calc_go), W'(1));
    chk("t1/state", W'(state), W'(2));
    idle(2);
    chk("t1/go_width", W'(calc_go), W'(0));

    // overflow then backspace
    send_seq('{9, 8, 7, 6});
    chk("t2/op_a", op_a, W'(12'h987));
    chk("t2/full", W'(entry_full), W'(1));
    send_key(13, s);
    chk("t2/disp", disp_bcd, W'(12'h098));
    chk("t2/full_bs", W'(entry_full), W'(0));
    idle(1);

    // operator overwrite and repeated '='
    send_seq('{14, 5, 10, 11, 7, 12});
    chk("t3/sign", W'(op_sign), W'(0));
    chk("t3/op_b", op_b, W'(12'h007));
    send_key(12, s);
    chk("t3/stall", W'(s), W'(1));
    chk("t3/go2", W'(calc_go), W'(1));
    chk("t3/op_a2", op_a, W'(12'h005));
    idle(1);

    // clear, then '=' in S_A does nothing
    send_seq('{1, 10, 2, 14});
    chk("t4/state", W'(state), W'(0));
    chk("t4/disp", disp_bcd, W'(0));
    send_key(12, s);
    chk("t4/no_go", W'(calc_go), W'(0));
    idle(1);

    // back-to-back keys across '=' stall exactly once
    b2b       = '{14, 2, 10, 3, 12, 4};
    exp_stall = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      send_key(b2b[i], s);
      chk($sformatf("t5/stall%0d", i), W'(s), W'(exp_stall[i]));
    end
    chk("t5/op_a", op_a, W'(12'h004));
    idle(1);

    // async reset mid-entry
    send_seq('{14, 4, 11, 3});
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6/rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

`ifdef CALC_IDLE_CLR_EN
    send_seq('{3, 10});
    idle(IDLE);
    chk("t7/state", W'(state), W'(0));
    chk("t7/op_a", op_a, W'(0));
`endif

    // random keys with random gaps
    for (int n = 0; n < 400; n++) begin
      int k;
      if ($urandom_range(0, 99) < 55) k = int'($urandom_range(0, 9));
      else k = int'($urandom_range(10, 15));
      send_key(k, s);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 39) == 0) idle(IDLE + 1);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
